alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 169 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational 8-bit ALU: registers one command, waits WAIT_CYCLES, captures the result.
// Optional feature macro CARRY_CHAIN_EN adds a carry flag usable as the carry-in of the next command.
module alu_issue_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [7:0]   cmd_a,
    input  logic [7:0]   cmd_b,
    input  logic         cmd_cin,
    input  logic         cmd_chain,
    output logic [119:0] alu_oper,
    output logic [7:0]   alu_a,
    output logic [7:0]   alu_b,
    output logic         alu_c_in,
    input  logic [7:0]   alu_sum,
    input  logic         alu_c_out,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [7:0]   rsp_data,
    output logic         rsp_carry,
    output logic [1:0]   dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // cmd_ready is 1 only in IDLE; rsp_valid stays 1 with stable data until rsp_ready is sampled 1.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [119:0]   alu_oper_q, alu_oper_d;
    logic [7:0]     alu_a_q, alu_a_d;
    logic [7:0]     alu_b_q, alu_b_d;
    logic           alu_c_in_q, alu_c_in_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [7:0]     rsp_data_q, rsp_data_d;
    logic           rsp_carry_q, rsp_carry_d;
    logic           cin_sel;

    function automatic logic [119:0] op_string(input logic [2:0] op);
        logic [119:0] s;
        case (op)
            3'd0:    s = "and";
            3'd1:    s = "subtract";
            3'd2:    s = "subtract_a";
            3'd3:    s = "or_ab";
            3'd4:    s = "and_ab";
            3'd5:    s = "not_ab";
            3'd6:    s = "exor";
            default: s = "exnor";
        endcase
        return s;
    endfunction

`ifdef CARRY_CHAIN_EN
    logic carry_q, carry_d;
    logic upd_q, upd_d;
    assign cin_sel = cmd_chain ? carry_q : cmd_cin;
`else
    logic unused_chain;
    assign unused_chain = cmd_chain;
    assign cin_sel      = cmd_cin;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_oper_d  = alu_oper_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_c_in_d  = alu_c_in_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
`ifdef CARRY_CHAIN_EN
        carry_d     = carry_q;
        upd_d       = upd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    alu_oper_d = op_string(cmd_op);
                    alu_a_d    = cmd_a;
                    alu_b_d    = cmd_b;
                    alu_c_in_d = cin_sel;
                    cnt_d      = WAIT_LD;
                    state_d    = S_WAIT;
`ifdef CARRY_CHAIN_EN
                    upd_d      = (cmd_op <= 3'd2);
`endif
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rsp_data_d  = alu_sum;
                    rsp_carry_d = alu_c_out;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
`ifdef CARRY_CHAIN_EN
                    // Only the arithmetic opcodes own the carry flag.
                    if (upd_q) carry_d = alu_c_out;
`endif
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            alu_oper_q  <= 120'b0;
            alu_a_q     <= 8'd0;
            alu_b_q     <= 8'd0;
            alu_c_in_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
            rsp_carry_q <= 1'b0;
`ifdef CARRY_CHAIN_EN
            carry_q     <= 1'b0;
            upd_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_oper_q  <= alu_oper_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_c_in_q  <= alu_c_in_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
`ifdef CARRY_CHAIN_EN
            carry_q     <= carry_d;
            upd_q       <= upd_d;
`endif
        end
    end

    // Gated by rst so nothing can be offered while reset is held.
    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign alu_oper  = alu_oper_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_c_in  = alu_c_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: two instances (WAIT_CYCLES=1 and 4) each paired with a string-opcode ALU model.
module tb_alu_issue_ctrl;

    logic         clk = 1'b0;
    logic         rst, rst4;
    int           n_cmp = 0;
    int           n_fail = 0;

    // WAIT_CYCLES = 1 instance
    logic         cmd_valid, cmd_ready, cmd_cin, cmd_chain;
    logic [2:0]   cmd_op;
    logic [7:0]   cmd_a, cmd_b;
    logic [119:0] alu_oper;
    logic [7:0]   alu_a, alu_b, alu_sum;
    logic         alu_c_in, alu_c_out;
    logic         rsp_valid, rsp_ready, rsp_carry;
    logic [7:0]   rsp_data;
    logic [1:0]   dbg_state;

    // WAIT_CYCLES = 4 instance
    logic         d4_cmd_valid, d4_cmd_ready, d4_cmd_cin, d4_cmd_chain;
    logic [2:0]   d4_cmd_op;
    logic [7:0]   d4_cmd_a, d4_cmd_b;
    logic [119:0] d4_alu_oper;
    logic [7:0]   d4_alu_a, d4_alu_b, d4_alu_sum;
    logic         d4_alu_c_in, d4_alu_c_out;
    logic         d4_rsp_valid, d4_rsp_ready, d4_rsp_carry;
    logic [7:0]   d4_rsp_data;
    logic [1:0]   d4_dbg_state;

    logic [119:0] exp_str [8];

    always #5 clk = ~clk;

    function automatic logic [8:0] alu_model(input logic [119:0] oper, input logic [7:0] a,
                                             input logic [7:0] b, input logic c);
        logic [119:0] s_add, s_sub, s_suba, s_or, s_and, s_not, s_xor, s_xnor;
        logic [8:0] r;
        s_add = "and"; s_sub = "subtract"; s_suba = "subtract_a"; s_or = "or_ab";
        s_and = "and_ab"; s_not = "not_ab"; s_xor = "exor"; s_xnor = "exnor";
        r = 9'd0;
        if (oper == s_add)       r = {1'b0, a} + {1'b0, b} + {8'd0, c};
        else if (oper == s_sub)  r = {1'b0, b} + {1'b0, ~a} + {8'd0, c};
        else if (oper == s_suba) r = {1'b0, a} + {1'b0, ~b} + {8'd0, c};
        else if (oper == s_or)   r = {1'b0, a | b};
        else if (oper == s_and)  r = {1'b0, a & b};
        else if (oper == s_not)  r = {1'b0, ~a & b};
        else if (oper == s_xor)  r = {1'b0, a ^ b};
        else if (oper == s_xnor) r = {1'b0, ~(a ^ b)};
        return r;
    endfunction

    assign {alu_c_out, alu_sum}       = alu_model(alu_oper, alu_a, alu_b, alu_c_in);
    assign {d4_alu_c_out, d4_alu_sum} = alu_model(d4_alu_oper, d4_alu_a, d4_alu_b, d4_alu_c_in);

    alu_issue_ctrl #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_chain(cmd_chain),
        .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in),
        .alu_sum(alu_sum), .alu_c_out(alu_c_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .dbg_state(dbg_state)
    );

    alu_issue_ctrl #(.WAIT_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst4), .cmd_valid(d4_cmd_valid), .cmd_ready(d4_cmd_ready), .cmd_op(d4_cmd_op),
        .cmd_a(d4_cmd_a), .cmd_b(d4_cmd_b), .cmd_cin(d4_cmd_cin), .cmd_chain(d4_cmd_chain),
        .alu_oper(d4_alu_oper), .alu_a(d4_alu_a), .alu_b(d4_alu_b), .alu_c_in(d4_alu_c_in),
        .alu_sum(d4_alu_sum), .alu_c_out(d4_alu_c_out), .rsp_valid(d4_rsp_valid),
        .rsp_ready(d4_rsp_ready), .rsp_data(d4_rsp_data), .rsp_carry(d4_rsp_carry),
        .dbg_state(d4_dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command once cmd_ready is seen; returns 1 ns after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic chain);
        int i;
        for (i = 0; i < 50 && !cmd_ready; i++) tick();
        if (!cmd_ready) begin
            n_fail++;
            $display("FAIL issue_timeout: cmd_ready=%b after 50 cycles, required 1", cmd_ready);
        end
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_chain = chain;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int i;
        for (i = 0; i < 50 && !rsp_valid; i++) tick();
        if (!rsp_valid) begin
            n_fail++;
            $display("FAIL rsp_timeout: rsp_valid=%b after 50 cycles, required 1", rsp_valid);
        end
    endtask

    task automatic get_rsp(output logic [7:0] d, output logic c);
        wait_rsp();
        d = rsp_data;
        c = rsp_carry;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst4 = 1'b1;
        cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; cmd_cin = 0; cmd_chain = 0; rsp_ready = 0;
        d4_cmd_valid = 0; d4_cmd_op = 0; d4_cmd_a = 0; d4_cmd_b = 0; d4_cmd_cin = 0;
        d4_cmd_chain = 0; d4_rsp_ready = 0;
        tick(); tick();
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_cmd_ready: got %b, required 0", cmd_ready);
        end
        n_cmp++;
        if ({rsp_valid, rsp_data, rsp_carry} !== 10'd0) begin
            n_fail++; $display("FAIL reset_rsp: got v=%b d=%h c=%b, required all 0", rsp_valid, rsp_data, rsp_carry);
        end
        n_cmp++;
        if ({alu_oper, alu_a, alu_b, alu_c_in} !== 137'd0) begin
            n_fail++; $display("FAIL reset_alu: got oper=%h a=%h b=%h c=%b, required all 0", alu_oper, alu_a, alu_b, alu_c_in);
        end
        n_cmp++;
        if (dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d, required 0", dbg_state);
        end
        rst = 1'b0; rst4 = 1'b0;
        tick();
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_ready: got %b, required 1", cmd_ready);
        end
    endtask

    task automatic test_add_latency();
        logic [119:0] s_add;
        s_add = "and";
        issue(3'd0, 8'h7F, 8'h01, 1'b0, 1'b0);
        n_cmp++;
        if (rsp_valid !== 1'b0 || dbg_state !== 2'd1 || cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL add_accept: got v=%b st=%0d rdy=%b, required v=0 st=1 rdy=0", rsp_valid, dbg_state, cmd_ready);
        end
        n_cmp++;
        if (alu_oper !== s_add || alu_a !== 8'h7F || alu_b !== 8'h01 || alu_c_in !== 1'b0) begin
            n_fail++; $display("FAIL add_alu_drive: got oper=%h a=%h b=%h c=%b, required \"and\" 7f 01 0", alu_oper, alu_a, alu_b, alu_c_in);
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h80 || rsp_carry !== 1'b0) begin
            n_fail++; $display("FAIL add_result: got v=%b d=%h c=%b, required v=1 d=80 c=0", rsp_valid, rsp_data, rsp_carry);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || alu_a !== 8'h7F) begin
            n_fail++; $display("FAIL add_handshake: got v=%b rdy=%b a=%h, required v=0 rdy=1 a=7f", rsp_valid, cmd_ready, alu_a);
        end
    endtask

    task automatic test_carry_chain();
        logic [7:0] d;
        logic       c;
        issue(3'd0, 8'hFF, 8'h01, 1'b0, 1'b0);
        get_rsp(d, c);
        n_cmp++;
        if (d !== 8'h00 || c !== 1'b1) begin
            n_fail++; $display("FAIL chain_first: got d=%h c=%b, required d=00 c=1", d, c);
        end
        issue(3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        get_rsp(d, c);
        n_cmp++;
`ifdef CARRY_CHAIN_EN
        if (d !== 8'h01 || c !== 1'b0) begin
            n_fail++; $display("FAIL chain_second: got d=%h c=%b, required d=01 c=0", d, c);
        end
`else
        if (d !== 8'h00 || c !== 1'b0) begin
            n_fail++; $display("FAIL chain_second: got d=%h c=%b, required d=00 c=0", d, c);
        end
`endif
    endtask

    task automatic test_subtract_logic();
        logic [7:0] d;
        logic       c;
        issue(3'd1, 8'h05, 8'h10, 1'b1, 1'b0);
        get_rsp(d, c);
        n_cmp++;
        if (d !== 8'h0B || c !== 1'b1) begin
            n_fail++; $display("FAIL subtract: got d=%h c=%b, required d=0b c=1", d, c);
        end
        issue(3'd6, 8'hF0, 8'h3C, 1'b0, 1'b0);
        get_rsp(d, c);
        n_cmp++;
        if (d !== 8'hCC || c !== 1'b0) begin
            n_fail++; $display("FAIL exor: got d=%h c=%b, required d=cc c=0", d, c);
        end
        // Flag should still hold the subtract carry, not the exor carry.
        issue(3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        get_rsp(d, c);
        n_cmp++;
`ifdef CARRY_CHAIN_EN
        if (d !== 8'h01) begin
            n_fail++; $display("FAIL flag_kept: got d=%h, required 01", d);
        end
`else
        if (d !== 8'h00) begin
            n_fail++; $display("FAIL flag_kept: got d=%h, required 00", d);
        end
`endif
    endtask

    task automatic test_all_ops();
        logic [7:0] exp_d [8];
        logic       exp_c [8];
        logic [7:0] d;
        logic       c;
        exp_str[0] = "and";    exp_str[1] = "subtract"; exp_str[2] = "subtract_a"; exp_str[3] = "or_ab";
        exp_str[4] = "and_ab"; exp_str[5] = "not_ab";   exp_str[6] = "exor";       exp_str[7] = "exnor";
        exp_d[0] = 8'h1D; exp_d[1] = 8'h96; exp_d[2] = 8'h68; exp_d[3] = 8'hDB;
        exp_d[4] = 8'h42; exp_d[5] = 8'h18; exp_d[6] = 8'h99; exp_d[7] = 8'h66;
        exp_c[0] = 1'b1;  exp_c[1] = 1'b0;  exp_c[2] = 1'b1;  exp_c[3] = 1'b0;
        exp_c[4] = 1'b0;  exp_c[5] = 1'b0;  exp_c[6] = 1'b0;  exp_c[7] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            issue(3'(i), 8'hC3, 8'h5A, 1'b0, 1'b0);
            n_cmp++;
            if (alu_oper !== exp_str[i]) begin
                n_fail++; $display("FAIL op%0d_string: got %h, required %h", i, alu_oper, exp_str[i]);
            end
            get_rsp(d, c);
            n_cmp++;
            if (d !== exp_d[i] || c !== exp_c[i]) begin
                n_fail++; $display("FAIL op%0d_result: got d=%h c=%b, required d=%h c=%b", i, d, c, exp_d[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] d;
        logic       c;
        issue(3'd3, 8'h12, 8'h21, 1'b0, 1'b0);
        wait_rsp();
        cmd_op = 3'd0; cmd_a = 8'h01; cmd_b = 8'h02; cmd_cin = 1'b0; cmd_chain = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h33 || cmd_ready !== 1'b0 || alu_a !== 8'h12) begin
                n_fail++; $display("FAIL stall_%0d: got v=%b d=%h rdy=%b a=%h, required v=1 d=33 rdy=0 a=12", i, rsp_valid, rsp_data, cmd_ready, alu_a);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || dbg_state !== 2'd0 || alu_a !== 8'h12) begin
            n_fail++; $display("FAIL stall_release: got v=%b st=%0d a=%h, required v=0 st=0 a=12", rsp_valid, dbg_state, alu_a);
        end
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if (alu_a !== 8'h01 || dbg_state !== 2'd1) begin
            n_fail++; $display("FAIL pending_accept: got a=%h st=%0d, required a=01 st=1", alu_a, dbg_state);
        end
        get_rsp(d, c);
        n_cmp++;
        if (d !== 8'h03 || c !== 1'b0) begin
            n_fail++; $display("FAIL pending_result: got d=%h c=%b, required d=03 c=0", d, c);
        end
    endtask

    task automatic test_reset_mid_wait();
        int seen;
        for (int i = 0; i < 20 && !d4_cmd_ready; i++) tick();
        d4_cmd_op = 3'd0; d4_cmd_a = 8'h11; d4_cmd_b = 8'h22; d4_cmd_cin = 1'b0;
        d4_cmd_valid = 1'b1;
        tick();
        d4_cmd_valid = 1'b0;
        tick();
        n_cmp++;
        if (d4_dbg_state !== 2'd1) begin
            n_fail++; $display("FAIL w4_in_wait: got st=%0d, required 1", d4_dbg_state);
        end
        rst4 = 1'b1;
        #1;
        n_cmp++;
        if ({d4_rsp_valid, d4_rsp_data, d4_rsp_carry, d4_cmd_ready, d4_dbg_state} !== 13'd0 ||
            {d4_alu_oper, d4_alu_a, d4_alu_b, d4_alu_c_in} !== 137'd0) begin
            n_fail++; $display("FAIL w4_reset_vals: got v=%b d=%h c=%b rdy=%b st=%0d a=%h b=%h, required all 0",
                               d4_rsp_valid, d4_rsp_data, d4_rsp_carry, d4_cmd_ready, d4_dbg_state, d4_alu_a, d4_alu_b);
        end
        tick();
        rst4 = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (d4_rsp_valid) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++; $display("FAIL w4_abandoned: rsp_valid seen %0d cycles, required 0", seen);
        end
        d4_cmd_op = 3'd0; d4_cmd_a = 8'h40; d4_cmd_b = 8'h05; d4_cmd_cin = 1'b1;
        d4_cmd_valid = 1'b1;
        tick();
        d4_cmd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp++;
            if (d4_rsp_valid !== (k == 4)) begin
                n_fail++; $display("FAIL w4_latency_%0d: got rsp_valid=%b, required %b", k, d4_rsp_valid, (k == 4));
            end
        end
        n_cmp++;
        if (d4_rsp_data !== 8'h46 || d4_rsp_carry !== 1'b0) begin
            n_fail++; $display("FAIL w4_result: got d=%h c=%b, required d=46 c=0", d4_rsp_data, d4_rsp_carry);
        end
        d4_rsp_ready = 1'b1;
        tick();
        d4_rsp_ready = 1'b0;
        n_cmp++;
        if (d4_rsp_valid !== 1'b0 || d4_cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL w4_handshake: got v=%b rdy=%b, required v=0 rdy=1", d4_rsp_valid, d4_cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_carry_chain();
        test_subtract_logic();
        test_all_ops();
        test_backpressure();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
